lcd_bus_seq: RTL and testbench

- Clocked sequencer for the HD44780-class character LCD port of the CPLD.
- Replaces direct decode of LCD E from MCU strobes: the MCU posts one command/data transaction.
- The block generates RS/RW setup, E pulse width, hold and E-low recovery timing in sys_clk cycles.
- It optionally polls the LCD busy flag (DB7) before each transfer and returns read data to the MCU.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_phase_tmr.sv | 40 ++++
 rtl/lcd_bus_seq.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_bus_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-class LCD bus sequencer.
//   - lcd_state_e : sequencer FSM state encoding
//   - *_DEF       : default timing constants in sys_clk cycles
//   - RS_* / RW_* : LCD register-select and read/write encodings
//   - max3        : helper used to size the shared phase counter
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPAs,   // poll: RS/RW setup
        StPEh,   // poll: E high
        StPEl,   // poll: E low / recovery
        StXAs,   // transfer: RS/RW (and write data) setup
        StXEh,   // transfer: E high
        StXEl,   // transfer: E low, data hold and recovery
        StDone
    } lcd_state_e;

    localparam int unsigned T_AS_DEF    = 2;
    localparam int unsigned T_PW_DEF    = 8;
    localparam int unsigned T_EL_DEF    = 12;
    localparam int unsigned BUSY_TO_DEF = 32'h0000_FFFF;

    localparam logic RS_INST = 1'b0;
    localparam logic RS_DATA = 1'b1;
    localparam logic RW_WR   = 1'b0;
    localparam logic RW_RD   = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_tmr.sv
// lcd_phase_tmr: loadable down-counter shared by all sequencer phases.
// Load the phase length minus one on phase entry; done_o is high in the last cycle of the phase,
// so a load value of 0 gives a one-cycle phase.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          load load_val_i this cycle (takes effect next cycle)
//   load_val_i      reload value
//   done_o          counter has reached zero
module lcd_phase_tmr #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_seq.sv
// lcd_bus_seq: clocked sequencer for the HD44780-class character LCD port.
// The MCU posts one command/data transaction; the block optionally polls the busy flag (DB7),
// then performs the transfer with RS/RW setup, E pulse width and E-low recovery timing.
// Ports:
//   sys_clk_i, sys_nrst_i        clock, asynchronous active-low reset
//   req_i, rs_i, rw_i, poll_en_i transaction request and its attributes (sampled in idle only)
//   wdat_i8                      write data
//   busy_o                       sequencer not idle
//   rdat_o8, rdat_vld_o          last read data, one-cycle update pulse
//   to_err_o, err_clr_i          sticky busy-poll timeout flag and its clear
//   lcd_rs_o, lcd_rw_o, lcd_e_o  LCD control pins
//   lcd_db_o8, lcd_db_oe_o       LCD data out and output enable
//   lcd_db_i8                    LCD data in
module lcd_bus_seq
    import lcd_pkg::*;
#(
    parameter int unsigned T_AS    = T_AS_DEF,
    parameter int unsigned T_PW    = T_PW_DEF,
    parameter int unsigned T_EL    = T_EL_DEF,
    parameter int unsigned BUSY_TO = BUSY_TO_DEF
) (
    input  logic       sys_clk_i,
    input  logic       sys_nrst_i,
    input  logic       req_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic       poll_en_i,
    input  logic [7:0] wdat_i8,
    output logic       busy_o,
    output logic [7:0] rdat_o8,
    output logic       rdat_vld_o,
    output logic       to_err_o,
    input  logic       err_clr_i,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_db_o8,
    output logic       lcd_db_oe_o,
    input  logic [7:0] lcd_db_i8
);

    localparam int unsigned TMax   = max3(T_AS, T_PW, T_EL);
    // Counter holds phase length minus one.
    localparam int unsigned CntW   = (TMax > 1) ? $clog2(TMax) : 1;
    localparam logic [15:0] BusyTo = 16'(BUSY_TO);

    lcd_state_e  state_d, state_q;
    logic        rs_d, rs_q;
    logic        rw_d, rw_q;
    logic [7:0]  wdat_d, wdat_q;
    logic [15:0] poll_cnt_d, poll_cnt_q;
    logic        bf_d, bf_q;
    logic [7:0]  rdat_d, rdat_q;
    logic        err_d, err_q;
    logic        err_set;

    logic            tmr_load;
    logic [CntW-1:0] tmr_load_val;
    logic            tmr_done;

    lcd_phase_tmr #(
        .Width(CntW)
    ) u_phase_tmr (
        .clk_i     (sys_clk_i),
        .rst_ni    (sys_nrst_i),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .done_o    (tmr_done)
    );

    // State register and datapath registers.
    always_ff @(posedge sys_clk_i or negedge sys_nrst_i) begin
        if (!sys_nrst_i) begin
            state_q    <= StIdle;
            rs_q       <= RS_INST;
            rw_q       <= RW_RD;
            wdat_q     <= 8'h00;
            poll_cnt_q <= 16'h0000;
            bf_q       <= 1'b0;
            rdat_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            wdat_q     <= wdat_d;
            poll_cnt_q <= poll_cnt_d;
            bf_q       <= bf_d;
            rdat_q     <= rdat_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        rw_d       = rw_q;
        wdat_d     = wdat_q;
        poll_cnt_d = poll_cnt_q;
        bf_d       = bf_q;
        rdat_d     = rdat_q;
        err_set    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    rs_d       = rs_i;
                    rw_d       = rw_i;
                    wdat_d     = wdat_i8;
                    poll_cnt_d = 16'h0000;
                    // poll_en is only needed for this branch, so it is used directly.
                    state_d    = poll_en_i ? StPAs : StXAs;
                end
            end
            StPAs: begin
                if (tmr_done) state_d = StPEh;
            end
            StPEh: begin
                if (tmr_done) begin
                    bf_d    = lcd_db_i8[7];
                    state_d = StPEl;
                end
            end
            StPEl: begin
                if (tmr_done) begin
                    if (!bf_q) begin
                        state_d = StXAs;
                    end else if (poll_cnt_q < BusyTo) begin
                        poll_cnt_d = poll_cnt_q + 16'd1;
                        state_d    = StPAs;
                    end else begin
                        // Give up polling; the transfer still goes ahead.
                        err_set = 1'b1;
                        state_d = StXAs;
                    end
                end
            end
            StXAs: begin
                if (tmr_done) state_d = StXEh;
            end
            StXEh: begin
                if (tmr_done) begin
                    if (rw_q == RW_RD) rdat_d = lcd_db_i8;
                    state_d = StXEl;
                end
            end
            StXEl: begin
                if (tmr_done) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Set wins over a simultaneous clear.
        err_d = (err_q & ~err_clr_i) | err_set;
    end

    // Phase timer reload on every state change.
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            StPAs, StXAs: tmr_load_val = CntW'(T_AS - 1);
            StPEh, StXEh: tmr_load_val = CntW'(T_PW - 1);
            StPEl, StXEl: tmr_load_val = CntW'(T_EL - 1);
            default:      tmr_load_val = '0;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        lcd_e_o     = 1'b0;
        lcd_rs_o    = RS_INST;
        lcd_rw_o    = RW_RD;
        lcd_db_oe_o = 1'b0;
        lcd_db_o8   = 8'h00;

        unique case (state_q)
            StPEh: begin
                lcd_e_o = 1'b1;
            end
            StXAs, StXEh, StXEl: begin
                lcd_rs_o = rs_q;
                lcd_rw_o = rw_q;
                lcd_e_o  = (state_q == StXEh);
                // Drive data from setup through the end of E-low, covering hold time.
                if (rw_q == RW_WR) begin
                    lcd_db_oe_o = 1'b1;
                    lcd_db_o8   = wdat_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy_o     = (state_q != StIdle);
    assign rdat_vld_o = (state_q == StDone) && (rw_q == RW_RD);
    assign rdat_o8    = rdat_q;
    assign to_err_o   = err_q;

endmodule

// File: tb/tb_lcd_bus_seq.sv
// tb_lcd_bus_seq: scoreboard bench for lcd_bus_seq with a behavioural LCD model.
module tb_lcd_bus_seq;

    localparam int T_AS    = 2;
    localparam int T_PW    = 8;
    localparam int T_EL    = 12;
    localparam int BUSY_TO = 4;
    localparam int TCYC    = T_AS + T_PW + T_EL;

    typedef struct {
        logic       rs;
        logic       rw;
        logic       oe;
        logic [7:0] db;
        int         lo;
    } pulse_t;

    typedef struct {
        int   len;
        logic err;
        int   oe_cyc;
    } txn_t;

    logic       sys_clk_i = 1'b0;
    logic       sys_nrst_i = 1'b0;
    logic       req_i = 1'b0;
    logic       rs_i = 1'b0;
    logic       rw_i = 1'b0;
    logic       poll_en_i = 1'b0;
    logic [7:0] wdat_i8 = 8'h00;
    logic       err_clr_i = 1'b0;
    logic       busy_o;
    logic [7:0] rdat_o8;
    logic       rdat_vld_o;
    logic       to_err_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic       lcd_e_o;
    logic [7:0] lcd_db_o8;
    logic       lcd_db_oe_o;
    logic [7:0] lcd_db_i8;

    int vectors = 0;
    int miscompares = 0;

    pulse_t     pulse_q[$];
    logic [7:0] rdat_q[$];
    txn_t       txn_q[$];
    logic       err_m = 1'b0;

    // LCD model: the first busy_reads reads of a transaction see DB7=1.
    int         busy_reads = 0;
    logic [7:0] rd_val = 8'h00;
    int         rd_cnt = 0;

    assign lcd_db_i8 = (rd_cnt < busy_reads) ? 8'hFF : rd_val;

    always #5 sys_clk_i = ~sys_clk_i;

    lcd_bus_seq #(
        .BUSY_TO(BUSY_TO)
    ) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_nrst_i (sys_nrst_i),
        .req_i      (req_i),
        .rs_i       (rs_i),
        .rw_i       (rw_i),
        .poll_en_i  (poll_en_i),
        .wdat_i8    (wdat_i8),
        .busy_o     (busy_o),
        .rdat_o8    (rdat_o8),
        .rdat_vld_o (rdat_vld_o),
        .to_err_o   (to_err_o),
        .err_clr_i  (err_clr_i),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_e_o    (lcd_e_o),
        .lcd_db_o8  (lcd_db_o8),
        .lcd_db_oe_o(lcd_db_oe_o),
        .lcd_db_i8  (lcd_db_i8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: derive expected pulses, read data and transaction summary, then
    // post the request. Attribute inputs are scrambled afterwards to show they were latched.
    task automatic issue(input logic rs, input logic rw, input logic poll, input logic [7:0] wd,
                         input int br, input logic [7:0] rdv);
        int     np;
        logic   tmo;
        pulse_t p;
        txn_t   t;
        np  = 0;
        tmo = 1'b0;
        if (poll) begin
            np  = (br < BUSY_TO + 1) ? br + 1 : BUSY_TO + 1;
            tmo = (br > BUSY_TO);
        end
        for (int i = 0; i < np; i++) begin
            p.rs = 1'b0; p.rw = 1'b1; p.oe = 1'b0; p.db = 8'h00;
            p.lo = (i == 0) ? T_AS : T_EL + T_AS;
            pulse_q.push_back(p);
        end
        p.rs = rs; p.rw = rw; p.oe = !rw; p.db = rw ? 8'h00 : wd;
        p.lo = (np == 0) ? T_AS : T_EL + T_AS;
        pulse_q.push_back(p);
        if (rw) rdat_q.push_back((br > np) ? 8'hFF : rdv);
        err_m    = err_m | tmo;
        t.len    = (np + 1) * TCYC + 1;
        t.err    = err_m;
        t.oe_cyc = rw ? 0 : TCYC;
        txn_q.push_back(t);
        busy_reads = br;
        rd_val     = rdv;
        @(posedge sys_clk_i); #1;
        req_i = 1'b1; rs_i = rs; rw_i = rw; poll_en_i = poll; wdat_i8 = wd;
        @(posedge sys_clk_i); #1;
        req_i = 1'b0;
        rs_i = 1'($urandom); rw_i = 1'($urandom); poll_en_i = 1'($urandom);
        wdat_i8 = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 1000) begin
            @(negedge sys_clk_i);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge sys_clk_i);
    endtask

    // LCD model: count completed reads within the current transaction.
    initial begin
        logic pe;
        pe = 1'b0;
        forever begin
            @(negedge sys_clk_i);
            if (!busy_o) rd_cnt = 0;
            else if (pe && !lcd_e_o && lcd_rw_o) rd_cnt++;
            pe = lcd_e_o;
        end
    end

    // Monitor: pops expectations when the DUT completes an E pulse, a read, or a transaction.
    initial begin
        logic       prev_e, prev_busy, rs_r, rw_r, oe_r, stable;
        logic [7:0] db_r;
        int         hi, lo, lo_at_rise, busy_len, oe_cyc, viol;
        pulse_t     p;
        txn_t       t;
        logic [7:0] r;
        prev_e = 0; prev_busy = 0; rs_r = 0; rw_r = 0; oe_r = 0; stable = 1; db_r = 0;
        hi = 0; lo = 0; lo_at_rise = 0; busy_len = 0; oe_cyc = 0; viol = 0;
        forever begin
            @(negedge sys_clk_i);
            if (!sys_nrst_i) begin
                prev_e = 0; prev_busy = 0; hi = 0; lo = 0; lo_at_rise = 0;
                busy_len = 0; oe_cyc = 0; viol = 0;
                continue;
            end
            if (busy_o) begin
                busy_len++;
                if (lcd_db_oe_o && lcd_rw_o) viol++;
                if (lcd_db_oe_o) oe_cyc++;
            end
            if (lcd_e_o) begin
                if (!prev_e) begin
                    rs_r = lcd_rs_o; rw_r = lcd_rw_o; stable = 1'b1; hi = 0; lo_at_rise = lo;
                end
                hi++;
                if (lcd_rs_o !== rs_r || lcd_rw_o !== rw_r) stable = 1'b0;
                oe_r = lcd_db_oe_o;
                db_r = lcd_db_o8;
            end else begin
                if (prev_e) begin
                    if (pulse_q.size() == 0) begin
                        check("pulse_unexpected", 32'd1, 32'd0);
                    end else begin
                        p = pulse_q.pop_front();
                        check("e_high_cycles", hi, T_PW);
                        check("e_low_before_rise", lo_at_rise, p.lo);
                        check("pulse_rs", {31'd0, rs_r}, {31'd0, p.rs});
                        check("pulse_rw", {31'd0, rw_r}, {31'd0, p.rw});
                        check("rs_rw_stable_in_e", {31'd0, stable}, 32'd1);
                        check("pulse_oe", {31'd0, oe_r}, {31'd0, p.oe});
                        if (p.oe) check("pulse_db", {24'd0, db_r}, {24'd0, p.db});
                    end
                    lo = 0;
                end
                if (busy_o) lo++;
                else lo = 0;
            end
            if (rdat_vld_o) begin
                if (rdat_q.size() == 0) begin
                    check("rdat_vld_unexpected", 32'd1, 32'd0);
                end else begin
                    r = rdat_q.pop_front();
                    check("rdat", {24'd0, rdat_o8}, {24'd0, r});
                end
            end
            if (prev_busy && !busy_o) begin
                if (txn_q.size() == 0) begin
                    check("txn_unexpected", 32'd1, 32'd0);
                end else begin
                    t = txn_q.pop_front();
                    check("busy_cycles", busy_len, t.len);
                    check("to_err_after_txn", {31'd0, to_err_o}, {31'd0, t.err});
                    check("oe_cycles", oe_cyc, t.oe_cyc);
                    check("oe_while_rw1", viol, 0);
                end
                busy_len = 0; oe_cyc = 0; viol = 0;
            end
            prev_e = lcd_e_o;
            prev_busy = busy_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values.
        #23;
        check("rst_lcd_e", {31'd0, lcd_e_o}, 32'd0);
        check("rst_lcd_rs", {31'd0, lcd_rs_o}, 32'd0);
        check("rst_lcd_rw", {31'd0, lcd_rw_o}, 32'd1);
        check("rst_lcd_oe", {31'd0, lcd_db_oe_o}, 32'd0);
        check("rst_lcd_db", {24'd0, lcd_db_o8}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_rdat", {24'd0, rdat_o8}, 32'd0);
        check("rst_rdat_vld", {31'd0, rdat_vld_o}, 32'd0);
        check("rst_to_err", {31'd0, to_err_o}, 32'd0);
        @(negedge sys_clk_i); #2;
        sys_nrst_i = 1'b1;

        // Reset while E is high during a write.
        issue(1'b1, 1'b0, 1'b0, 8'h99, 0, 8'h00);
        n = 0;
        while (!lcd_e_o && n < 100) begin
            @(negedge sys_clk_i);
            n++;
        end
        check("wait_e_high", {31'd0, lcd_e_o}, 32'd1);
        @(negedge sys_clk_i); #2;
        sys_nrst_i = 1'b0;
        #1;
        check("midrst_lcd_e", {31'd0, lcd_e_o}, 32'd0);
        check("midrst_oe", {31'd0, lcd_db_oe_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        pulse_q.delete(); rdat_q.delete(); txn_q.delete(); err_m = 1'b0;
        @(negedge sys_clk_i); #2;
        sys_nrst_i = 1'b1;
        @(negedge sys_clk_i);

        // Plain data write.
        issue(1'b1, 1'b0, 1'b0, 8'h41, 0, 8'h00);
        wait_idle();
        // Instruction-register read.
        issue(1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h3C);
        wait_idle();
        // Busy for three polls, then write.
        issue(1'b0, 1'b0, 1'b1, 8'h01, 3, 8'h00);
        wait_idle();

        // Timeout with the clear landing in the same cycle as the set.
        issue(1'b0, 1'b0, 1'b1, 8'h01, 100, 8'h00);
        repeat ((BUSY_TO + 1) * TCYC - 1) @(posedge sys_clk_i);
        #1 err_clr_i = 1'b1;
        @(posedge sys_clk_i);
        #1 err_clr_i = 1'b0;
        wait_idle();
        @(posedge sys_clk_i);
        #1 err_clr_i = 1'b1;
        @(posedge sys_clk_i);
        #1 err_clr_i = 1'b0;
        err_m = 1'b0;
        @(negedge sys_clk_i);
        check("to_err_cleared", {31'd0, to_err_o}, 32'd0);

        // Request while busy is ignored.
        issue(1'b1, 1'b0, 1'b0, 8'hAA, 0, 8'h00);
        repeat (5) @(posedge sys_clk_i);
        #1 req_i = 1'b1; wdat_i8 = 8'h55; rs_i = 1'b0; rw_i = 1'b0;
        @(posedge sys_clk_i);
        #1 req_i = 1'b0;
        wait_idle();

        // Randomised transactions.
        for (int k = 0; k < 40; k++) begin
            logic rs, rw, poll;
            int   br;
            rs   = 1'($urandom);
            rw   = 1'($urandom);
            poll = 1'($urandom);
            br   = poll ? int'($urandom_range(0, 6)) : 0;
            issue(rs, rw, poll, 8'($urandom), br, 8'($urandom) & 8'h7F);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 10)) @(posedge sys_clk_i);
                #1 req_i = 1'b1; wdat_i8 = 8'($urandom);
                @(posedge sys_clk_i);
                #1 req_i = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge sys_clk_i);
        end

        repeat (3) @(negedge sys_clk_i);
        check("pulse_q_empty", pulse_q.size(), 0);
        check("rdat_q_empty", rdat_q.size(), 0);
        check("txn_q_empty", txn_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
